// File: rtl/rgb_breathe_pwm_pkg.sv
// Shared definitions for the multi-channel breathing PWM driver:
// duty-source mode encodings, ramp direction and a duty clamp helper.
package rgb_breathe_pwm_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_STATIC = 2'b01,
      MODE_SAW    = 2'b10,
      MODE_TRI    = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   function automatic logic [31:0] clamp_duty(input logic [31:0] val, input logic [31:0] max_val);
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/rgb_breathe_pwm_core.sv
// Shared PWM timebase: prescaler, R-bit duty counter and period-boundary detect.
module pwm_core
   import rgb_breathe_pwm_pkg::*;
#(
   parameter int R  = 8,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] dvsr,
   output logic          tick,
   output logic          boundary,
   output logic [R-1:0]  d
);

   logic [DW-1:0] q_reg;
   logic [R-1:0]  d_reg;

   // Equality compare only: a counter already past a freshly lowered dvsr
   // rolls over through all-ones instead of ticking early.
   assign tick     = (q_reg == dvsr);
   assign boundary = tick && (d_reg == {R{1'b1}});
   assign d        = d_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg <= '0;
         d_reg <= '0;
      end else begin
         q_reg <= tick ? '0 : q_reg + DW'(1);
         if (tick)
            d_reg <= d_reg + R'(1);
      end
   end

endmodule

// File: rtl/rgb_breathe_pwm.sv
// Multi-channel PWM LED driver with off/static/sawtooth/triangle duty sequencer;
// active duty reloads only at period boundaries so outputs never glitch mid-period.
module rgb_breathe_pwm
   import rgb_breathe_pwm_pkg::*;
#(
   parameter int CH = 3,
   parameter int R  = 8,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] dvsr,
   input  logic [DW-1:0] step_div,
   input  logic [1:0]    mode,
   input  logic [CH-1:0] ch_mask,
   input  logic [CH-1:0] ch_inv,
   input  logic [R:0]    duty_in,
   output logic [CH-1:0] pwm_out,
   output logic [R:0]    duty_cur,
   output logic          period_tick
);

   typedef logic [R:0] duty_t;
   localparam duty_t DUTY_MAX = {1'b1, {R{1'b0}}};
   localparam duty_t DUTY_ONE = duty_t'(1);

   logic          tick;
   logic          boundary;
   logic [R-1:0]  d;
   logic          unused_tick;

   mode_e         mode_cur;
   mode_e         mode_reg;
   logic          mode_chg;
   logic [DW-1:0] s_reg;
   logic          step;
   duty_t         ramp_reg, ramp_next;
   dir_e          dir_reg, dir_next;
   duty_t         shadow;
   duty_t         active_reg;
   logic [CH-1:0] hit;
   logic [CH-1:0] pwm_reg;
   logic          period_tick_reg;

   pwm_core #(.R(R), .DW(DW)) u_core (
      .clk      (clk),
      .rst      (rst),
      .dvsr     (dvsr),
      .tick     (tick),
      .boundary (boundary),
      .d        (d)
   );

   assign unused_tick = tick;
   assign mode_cur    = mode_e'(mode);
   assign mode_chg    = (mode_cur != mode_reg);
   assign step        = (s_reg == step_div);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_reg <= MODE_OFF;
         s_reg    <= '0;
         ramp_reg <= '0;
         dir_reg  <= DIR_UP;
      end else begin
         mode_reg <= mode_cur;
         s_reg    <= (mode_chg || step) ? '0 : s_reg + DW'(1);
         ramp_reg <= ramp_next;
         dir_reg  <= dir_next;
      end
   end

   // Triangle turns around on the endpoint itself so 0 and 2^R each last one step.
   always_comb begin
      ramp_next = ramp_reg;
      dir_next  = dir_reg;
      if (mode_chg || mode_cur == MODE_OFF) begin
         ramp_next = '0;
         dir_next  = DIR_UP;
      end else if (step) begin
         case (mode_cur)
            MODE_SAW: ramp_next = (ramp_reg == DUTY_MAX) ? '0 : ramp_reg + DUTY_ONE;
            MODE_TRI: begin
               if (dir_reg == DIR_UP) begin
                  ramp_next = ramp_reg + DUTY_ONE;
                  if (ramp_reg == DUTY_MAX - DUTY_ONE)
                     dir_next = DIR_DOWN;
               end else begin
                  ramp_next = ramp_reg - DUTY_ONE;
                  if (ramp_reg == DUTY_ONE)
                     dir_next = DIR_UP;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      shadow = ramp_reg;
      if (mode_cur == MODE_STATIC)
         shadow = duty_t'(clamp_duty(32'(duty_in), 32'(DUTY_MAX)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         active_reg <= '0;
      else if (mode_cur == MODE_OFF)
         active_reg <= '0;
      else if (boundary)
         active_reg <= shadow;
   end

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         duty_t dch;
         assign dch     = ch_inv[gi] ? (DUTY_MAX - active_reg) : active_reg;
         assign hit[gi] = ch_mask[gi] & ({1'b0, d} < dch);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_reg         <= '0;
         period_tick_reg <= 1'b0;
      end else begin
         pwm_reg         <= hit;
         period_tick_reg <= boundary;
      end
   end

   assign pwm_out     = pwm_reg;
   assign duty_cur    = active_reg;
   assign period_tick = period_tick_reg;

endmodule

// File: doc/rgb_breathe_pwm.md
Name: rgb_breathe_pwm

Overview:
- Multi-channel PWM LED driver with a built-in duty sequencer; successor to the single-channel, fixed-sawtooth board-top PWM.
- Generates CH glitch-free PWM outputs from one shared counter.
- Duty source is run-time selectable: off, static, sawtooth ramp, or triangle "breathe" with optional per-channel phase inversion.
- Sits directly under the board top; drives rgb LEDs from switch-decoded mode/mask inputs.

Parameters:
- CH, 3, number of PWM output channels.
- R, 8, PWM resolution in bits; duty range 0..2^R, where 2^R means 100 %.
- DW, 32, width of the dvsr and step_div divisor inputs.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- dvsr  in  DW  PWM tick prescale; PWM counter advances every dvsr+1 clk.
- step_div  in  DW  sequencer step period in clk cycles, minus 1.
- mode  in  2  00 off, 01 static, 10 sawtooth, 11 triangle.
- ch_mask  in  CH  per-channel enable.
- ch_inv  in  CH  per-channel duty inversion (2^R − duty); gives anti-phase breathing.
- duty_in  in  R+1  static-mode duty; values above 2^R are clamped to 2^R.
- pwm_out  out  CH  registered PWM outputs.
- duty_cur  out  R+1  duty currently active for non-inverted channels.
- period_tick  out  1  one-clk pulse at each PWM period boundary.

Behaviour:
- Reset (asynchronous): all counters 0, dir = up, ramp = 0, active duty = 0, pwm_out = 0, period_tick = 0.
- Prescaler: q counts 0..dvsr. tick = (q == dvsr). dvsr = 0 gives tick every clk.
- PWM counter d (R bits): increments on tick and wraps 2^R−1 → 0.
  - Period boundary = tick while d == 2^R−1.
  - period_tick is registered and asserts on the cycle after the boundary.
- Step timer: s counts 0..step_div independently of the PWM. step = (s == step_div).
- Ramp register (R+1 bits), updated on step:
  - Sawtooth: 0, 1, …, 2^R, then 0. Dir is ignored.
  - Triangle: increments while dir = up; on reaching 2^R sets dir = down. Decrements while down; on reaching 0 sets dir = up. Endpoints are held for exactly one step; no skipped or duplicated values.
  - Static: ramp is not advanced.
  - Off: ramp is held at 0 and dir = up.
- Mode change: detected by comparing against a registered copy of mode. On the cycle after any change, ramp = 0 and dir = up; step timer is restarted.
- Shadow duty: next = clamp(duty_in) in static mode, otherwise ramp.
  - Active duty is loaded from shadow only at a period boundary, so there is no mid-period glitch.
  - Exception: mode 00 forces active duty to 0 immediately on the next clk.
- Per-channel duty: dch = ch_inv[i] ? 2^R − active : active.
- Output: pwm_out[i] <= ch_mask[i] & (d < dch), registered, one clk after d.
  - dch = 0 gives constant low.
  - dch = 2^R gives constant high.
- Simultaneous step and period boundary on the same clk: the boundary loads the pre-step ramp; the new ramp value is loaded at the following boundary.
- dvsr or step_div changed mid-count: the new value is compared immediately. If the counter already exceeds the new value, it runs to all-ones and wraps, without an early tick.
- duty_cur = active duty; its reset value is 0.

Decomposition:
- Shared package: mode encodings (MODE_OFF, MODE_STATIC, MODE_SAW, MODE_TRI) and a clamp helper function.
- One sub-module: pwm_core. It holds the prescaler, the d counter and the period-boundary detect, and exports tick, boundary and d.
- Sequencer, shadow/active duty registers and per-channel comparators stay in rgb_breathe_pwm.

Test Plan (R=4, CH=3, dvsr=0, step_div=0 unless noted):
- Reset mid-run: assert rst asynchronously mid-period → pwm_out = 0 and duty_cur = 0 in the same cycle, with no clk edge required.
- Static mode, duty_in = 4, ch_mask = 111 → each channel is high 4 of every 16 clk. duty_in = 31 → clamped to 16, all outputs constant high. duty_in = 0 → constant low.
- Sawtooth, step_div = 15 → duty_cur at successive period boundaries reads 0, 1, …, 16, 0. No pwm_out edge occurs except at a boundary or a compare crossing.
- Triangle, ch_inv = 010 → duty_cur sequence is 0…16, 15…0, 1…, with 16 and 0 each held for one step. Channel 1 duty always equals 16 − duty_cur.
- Mode change: switch mode 11 → 10 mid-ramp at ramp = 9 → ramp = 0 and dir = up next clk. Switch mode → 00 → all pwm_out low within 2 clk.
- dvsr = 3 → period_tick spacing is 64 clk. Step and boundary coincide → the new duty appears one period later.
